// File: rtl/verificador_sequencia.sv
// Checks a stream of entered digits against a latched expected sequence (pista),
// counting errors, with an optional idle timeout and terminal SUCESSO/FALHA states.
module verificador_sequencia #(
  parameter int DIGIT_W        = 4,
  parameter int SEQ_LEN        = 6,
  parameter int MAX_ERROS      = 2,
  parameter int TIMEOUT_CICLOS = 0,
  localparam int POS_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int ERR_W = $clog2(MAX_ERROS + 1),
  localparam int TMO_W = (TIMEOUT_CICLOS > 0) ? $clog2(TIMEOUT_CICLOS + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iniciar,
  input  logic [SEQ_LEN*DIGIT_W-1:0] pista,
  input  logic                       numero_valido,
  input  logic [DIGIT_W-1:0]         numero,
  output logic [2:0]                 estado,
  output logic [POS_W-1:0]           posicao,
  output logic [ERR_W-1:0]           erros,
  output logic                       acerto,
  output logic                       erro_ocorrido,
  output logic                       sucesso,
  output logic                       falha
);

  typedef enum logic [2:0] {
    OCIOSO       = 3'b000,
    VERIFICA     = 3'b001,
    SUCESSO      = 3'b010,
    ERRO_PARCIAL = 3'b011,
    FALHA        = 3'b100
  } estado_t;

  estado_t                    estado_q, estado_d;
  logic [POS_W-1:0]           posicao_d;
  logic [ERR_W-1:0]           erros_d, erros_inc;
  logic [TMO_W-1:0]           timer_q, timer_d;
  logic [SEQ_LEN*DIGIT_W-1:0] pista_q, pista_d;
  logic                       acerto_d, erro_d;
  logic                       tmo_expirou, mismatch;
  logic [DIGIT_W-1:0]         digitos [SEQ_LEN];
  logic [DIGIT_W-1:0]         esperado;

  // Slot 0 sits in the MSBs of pista, so unpack from the top down.
  always_comb begin
    for (int i = 0; i < SEQ_LEN; i++) begin
      digitos[i] = pista_q[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  assign esperado    = digitos[posicao];
  assign erros_inc   = (erros == ERR_W'(MAX_ERROS)) ? erros : erros + ERR_W'(1);
  assign tmo_expirou = (TIMEOUT_CICLOS != 0) &&
                       (timer_q + TMO_W'(1) == TMO_W'(TIMEOUT_CICLOS));
  assign estado      = estado_q;

  always_comb begin
    estado_d  = estado_q;
    posicao_d = posicao;
    erros_d   = erros;
    timer_d   = '0;
    pista_d   = pista_q;
    acerto_d  = 1'b0;
    erro_d    = 1'b0;
    mismatch  = 1'b0;

    if (iniciar) begin
      pista_d   = pista;
      posicao_d = '0;
      erros_d   = '0;
      estado_d  = VERIFICA;
    end else begin
      case (estado_q)
        OCIOSO: ;
        VERIFICA: begin
          // A valid digit always wins over an expiring timeout.
          if (numero_valido) begin
            if (numero == esperado) begin
              acerto_d = 1'b1;
              if (posicao == POS_W'(SEQ_LEN - 1)) estado_d = SUCESSO;
              else                                posicao_d = posicao + POS_W'(1);
            end else begin
              mismatch = 1'b1;
            end
          end else if (tmo_expirou) begin
            mismatch = 1'b1;
          end else if (TIMEOUT_CICLOS != 0) begin
            timer_d = timer_q + TMO_W'(1);
          end

          if (mismatch) begin
            erro_d    = 1'b1;
            erros_d   = erros_inc;
            posicao_d = '0;
            estado_d  = (erros_inc == ERR_W'(MAX_ERROS)) ? FALHA : ERRO_PARCIAL;
          end
        end
        ERRO_PARCIAL: estado_d = VERIFICA;
        SUCESSO, FALHA: ;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= OCIOSO;
      posicao       <= '0;
      erros         <= '0;
      timer_q       <= '0;
      pista_q       <= '0;
      acerto        <= 1'b0;
      erro_ocorrido <= 1'b0;
      sucesso       <= 1'b0;
      falha         <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      posicao       <= posicao_d;
      erros         <= erros_d;
      timer_q       <= timer_d;
      pista_q       <= pista_d;
      acerto        <= acerto_d;
      erro_ocorrido <= erro_d;
      sucesso       <= (estado_d == SUCESSO);
      falha         <= (estado_d == FALHA);
    end
  end

endmodule

// File: doc/verificador_sequencia.md
Name: verificador_sequencia

Overview:
Clocked, parametrised checker that validates a stream of entered digits against a latched expected sequence ("pista"). It tracks position and error count, can apply an optional inactivity timeout, and ends in total success or failure. It sits between the digit-entry front end and the game-control/display logic. It generalises the earlier combinational verifier with configurable digit width, sequence length, error budget and timeout.

Parameters:
DIGIT_W, 4, bits per digit
SEQ_LEN, 6, digits per sequence (>=2)
MAX_ERROS, 2, errors that cause FALHA (>=1)
TIMEOUT_CICLOS, 0, idle cycles in VERIFICA counted as one error; 0 disables the timeout
(derived) POS_W = max(1,clog2(SEQ_LEN)); ERR_W = clog2(MAX_ERROS+1); TMO_W = max(1,clog2(TIMEOUT_CICLOS+1))

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
iniciar  input  1  start/restart pulse; latches pista
pista  input  SEQ_LEN*DIGIT_W  expected sequence; slot 0 occupies the MSBs
numero_valido  input  1  numero is valid this cycle
numero  input  DIGIT_W  entered digit
estado  output  3  current state: 000 OCIOSO, 001 VERIFICA, 010 SUCESSO, 011 ERRO_PARCIAL, 100 FALHA
posicao  output  POS_W  index of the next expected digit
erros  output  ERR_W  errors accumulated in this round
acerto  output  1  one-cycle pulse on a correct digit
erro_ocorrido  output  1  one-cycle pulse on a mismatch or timeout
sucesso  output  1  level, high while in SUCESSO
falha  output  1  level, high while in FALHA

Behaviour:
- All outputs are registered. rst_n low (async) forces estado=OCIOSO; posicao, erros, acerto, erro_ocorrido, sucesso, falha, the timeout counter and the pista register all go to 0.
- Expected digit = pista_reg[SEQ_LEN*DIGIT_W-1 - posicao*DIGIT_W -: DIGIT_W].
- iniciar is accepted in every state and has top priority. It latches pista into pista_reg and clears posicao, erros and the timer. Next state is VERIFICA. Any numero_valido in the same cycle is discarded.
- OCIOSO: waits for iniciar. numero_valido is ignored.
- VERIFICA, numero_valido=1, numero matches: acerto=1 next cycle and the timer clears.
  - If posicao==SEQ_LEN-1, go to SUCESSO; posicao holds at SEQ_LEN-1.
  - Otherwise posicao increments.
- VERIFICA, numero_valido=1, numero mismatches: erro_ocorrido=1, erros increments, posicao goes to 0, timer clears.
  - If the new erros==MAX_ERROS, go to FALHA.
  - Otherwise go to ERRO_PARCIAL.
- Timeout (TIMEOUT_CICLOS>0): the timer counts cycles in VERIFICA with numero_valido=0. When it reaches TIMEOUT_CICLOS it is treated exactly as a mismatch and the timer clears. A numero_valido in the same cycle takes precedence over the timeout.
- ERRO_PARCIAL lasts exactly one cycle, then returns to VERIFICA. numero_valido in this cycle is ignored. The timer is held at 0.
- SUCESSO and FALHA are terminal; only iniciar or rst_n leaves them. numero_valido is ignored and erros/posicao hold.
- acerto and erro_ocorrido are never both high. Both are 0 in every cycle without a qualifying event.
- Latency: a digit presented at edge N is reflected in estado/posicao/pulses after edge N. There are no back-to-back input restrictions in VERIFICA.
- erros saturates at MAX_ERROS and never wraps.
- Illegal estado encodings return to OCIOSO on the next edge.

Test Plan:
- Defaults, pista=24'h123456, iniciar, then digits 1,2,3,4,5,6 on consecutive cycles -> six acerto pulses; estado=010 and sucesso=1 after the 6th; posicao=5; erros=0.
- Same pista, digits 1,2,9 -> erro_ocorrido pulse, estado=011 for one cycle then 001, posicao=0, erros=1. Then digits 7 -> estado=100, falha=1, erros=2.
- TIMEOUT_CICLOS=10, iniciar, no input -> erro_ocorrido after the 10th idle cycle, estado 011 then 001, erros=1. A further 10 idle cycles -> FALHA.
- In VERIFICA at posicao=3, assert iniciar and numero_valido together with new pista=24'hABCDEF -> estado=001, posicao=0, erros=0, no pulses; the next expected digit is A.
- numero_valido with a wrong digit during the ERRO_PARCIAL cycle -> ignored, erros unchanged. Digits in SUCESSO/FALHA -> no pulses.
- Assert rst_n=0 asynchronously mid-sequence (between edges) -> outputs are 0 and estado=000 immediately. After release, digits are ignored until iniciar.
